// File: rtl/algo_3r3w_b798_rdchk_if.sv
// Host-side port bundle of the 3R3W core, as seen by the read-data checker.
interface algo_3r3w_b798_rdchk_if #(
    parameter int NUMRDPRT = 3,
    parameter int NUMWRPRT = 3,
    parameter int WIDTH    = 15,
    parameter int BITADDR  = 8
);
    logic [NUMRDPRT-1:0]         read;
    logic [NUMRDPRT*BITADDR-1:0] rd_adr;
    logic [NUMRDPRT-1:0]         rd_vld;
    logic [NUMRDPRT*WIDTH-1:0]   rd_dout;
    logic [NUMWRPRT-1:0]         write;
    logic [NUMWRPRT*BITADDR-1:0] wr_adr;
    logic [NUMWRPRT*WIDTH-1:0]   din;
    logic [NUMWRPRT*WIDTH-1:0]   bw;

    modport master (output read, rd_adr, rd_vld, rd_dout, write, wr_adr, din, bw);
    modport slave  (input  read, rd_adr, rd_vld, rd_dout, write, wr_adr, din, bw);
endinterface

// File: rtl/algo_3r3w_b798_rdchk.sv
// Golden-model read checker for the 3R3W core: shadow memory with per-bit init mask,
// read-latency pipe, per-port comparators, first-error capture and saturating count.
module algo_3r3w_b798_rdchk_lane #(
    parameter int WIDTH = 15
) (
    input  logic             exp_vld,
    input  logic             rd_vld,
    input  logic [WIDTH-1:0] rd_dout,
    input  logic [WIDTH-1:0] exp,
    input  logic [WIDTH-1:0] msk,
    output logic             err,
    output logic [1:0]       typ
);
    always_comb begin
        err = 1'b0;
        typ = 2'd0;
        if (exp_vld && !rd_vld) begin
            err = 1'b1;
            typ = 2'd1;
        end else if (!exp_vld && rd_vld) begin
            err = 1'b1;
            typ = 2'd2;
        end else if (exp_vld && rd_vld && (((rd_dout ^ exp) & msk) != '0)) begin
            err = 1'b1;
            typ = 2'd3;
        end
    end
endmodule

module algo_3r3w_b798_rdchk #(
    parameter int NUMRDPRT = 3,
    parameter int NUMWRPRT = 3,
    parameter int WIDTH    = 15,
    parameter int BITADDR  = 8,
    parameter int NUMADDR  = 256,
    parameter int RD_LAT   = 2,
    parameter int FLOPOUT  = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flopout_en,
    algo_3r3w_b798_rdchk_if.slave      bus,
    output logic                       err_vld,
    output logic                       err_first,
    output logic [1:0]                 err_port,
    output logic [1:0]                 err_type,
    output logic [BITADDR-1:0]         err_adr,
    output logic [WIDTH-1:0]           err_exp,
    output logic [15:0]                err_cnt
);
    localparam int STAGES = RD_LAT + 1;
    localparam int AW     = (NUMADDR > 1) ? $clog2(NUMADDR) : 1;

    logic [WIDTH-1:0] mem  [NUMADDR];
    logic [WIDTH-1:0] init [NUMADDR];

    logic [NUMWRPRT-1:0][BITADDR-1:0] wa;
    logic [NUMWRPRT-1:0][WIDTH-1:0]   wd, wb, wr_val, wr_bwor;
    logic [NUMWRPRT-1:0]              wr_ok;
    logic [NUMRDPRT-1:0][BITADDR-1:0] ra;
    logic [NUMRDPRT-1:0][WIDTH-1:0]   rdo, rd_exp, rd_msk;

    assign wa  = bus.wr_adr;
    assign wd  = bus.din;
    assign wb  = bus.bw;
    assign ra  = bus.rd_adr;
    assign rdo = bus.rd_dout;

    // Every port hitting an address computes the fully merged word, so the
    // per-port stores below agree and store order does not matter.
    always_comb begin
        for (int p = 0; p < NUMWRPRT; p++) begin
            wr_ok[p]   = bus.write[p] && (int'(wa[p]) < NUMADDR);
            wr_val[p]  = wr_ok[p] ? mem[wa[p][AW-1:0]] : '0;
            wr_bwor[p] = '0;
            for (int q = 0; q < NUMWRPRT; q++) begin
                if (bus.write[q] && (wa[q] == wa[p])) begin
                    wr_val[p]  = (wr_val[p] & ~wb[q]) | (wd[q] & wb[q]);
                    wr_bwor[p] = wr_bwor[p] | wb[q];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < NUMWRPRT; p++)
            if (wr_ok[p]) mem[wa[p][AW-1:0]] <= wr_val[p];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < NUMADDR; a++) init[a] <= '0;
        end else begin
            for (int p = 0; p < NUMWRPRT; p++)
                if (wr_ok[p]) init[wa[p][AW-1:0]] <= init[wa[p][AW-1:0]] | wr_bwor[p];
        end
    end

    // Read-old-data: sampled combinationally before this cycle's writes land.
    always_comb begin
        for (int p = 0; p < NUMRDPRT; p++) begin
            rd_exp[p] = '0;
            rd_msk[p] = '0;
            if (int'(ra[p]) < NUMADDR) begin
                rd_exp[p] = mem[ra[p][AW-1:0]];
                rd_msk[p] = init[ra[p][AW-1:0]];
            end
        end
    end

    logic [STAGES:1][NUMRDPRT-1:0]              vld_pipe;
    logic [STAGES:1][NUMRDPRT-1:0][BITADDR-1:0] adr_pipe;
    logic [STAGES:1][NUMRDPRT-1:0][WIDTH-1:0]   exp_pipe, msk_pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            adr_pipe <= '0;
            exp_pipe <= '0;
            msk_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], bus.read};
            adr_pipe <= {adr_pipe[STAGES-1:1], ra};
            exp_pipe <= {exp_pipe[STAGES-1:1], rd_exp};
            msk_pipe <= {msk_pipe[STAGES-1:1], rd_msk};
        end
    end

    logic                             use_flop;
    logic [NUMRDPRT-1:0]              tap_vld;
    logic [NUMRDPRT-1:0][BITADDR-1:0] tap_adr;
    logic [NUMRDPRT-1:0][WIDTH-1:0]   tap_exp, tap_msk;

    assign use_flop = (FLOPOUT != 0) && flopout_en;
    assign tap_vld  = use_flop ? vld_pipe[RD_LAT+1] : vld_pipe[RD_LAT];
    assign tap_adr  = use_flop ? adr_pipe[RD_LAT+1] : adr_pipe[RD_LAT];
    assign tap_exp  = use_flop ? exp_pipe[RD_LAT+1] : exp_pipe[RD_LAT];
    assign tap_msk  = use_flop ? msk_pipe[RD_LAT+1] : msk_pipe[RD_LAT];

    logic [NUMRDPRT-1:0]       lane_err;
    logic [NUMRDPRT-1:0][1:0]  lane_typ;

    for (genvar p = 0; p < NUMRDPRT; p++) begin : g_lane
        algo_3r3w_b798_rdchk_lane #(.WIDTH(WIDTH)) u_lane (
            .exp_vld (tap_vld[p]),
            .rd_vld  (bus.rd_vld[p]),
            .rd_dout (rdo[p]),
            .exp     (tap_exp[p]),
            .msk     (tap_msk[p]),
            .err     (lane_err[p]),
            .typ     (lane_typ[p])
        );
    end

    int          n_err;
    int          sel;
    logic [16:0] cnt_sum;

    always_comb begin
        n_err = 0;
        sel   = 0;
        for (int p = NUMRDPRT - 1; p >= 0; p--) begin
            if (lane_err[p]) begin
                n_err = n_err + 1;
                sel   = p;
            end
        end
        cnt_sum = {1'b0, err_cnt} + 17'(n_err);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_vld   <= 1'b0;
            err_first <= 1'b0;
            err_port  <= '0;
            err_type  <= '0;
            err_adr   <= '0;
            err_exp   <= '0;
            err_cnt   <= '0;
        end else begin
            err_vld <= |lane_err;
            err_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
            if ((|lane_err) && !err_first) begin
                err_first <= 1'b1;
                err_port  <= 2'(sel);
                err_type  <= lane_typ[sel];
                err_adr   <= tap_adr[sel];
                err_exp   <= tap_exp[sel];
            end
        end
    end
endmodule

// File: tb/tb_algo_3r3w_b798_rdchk.sv
// Bench for the 3R3W read checker: the bench plays the core, injects faults and
// scoreboards the error events each injected fault must raise.
module tb_algo_3r3w_b798_rdchk;
    localparam int NR = 3, NW = 3, W = 15, BA = 8, NA = 256, RL = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flopout_en = 1'b0;
    logic          err_vld, err_first;
    logic [1:0]    err_port, err_type;
    logic [BA-1:0] err_adr;
    logic [W-1:0]  err_exp;
    logic [15:0]   err_cnt;

    always #5 clk = ~clk;

    algo_3r3w_b798_rdchk_if #(.NUMRDPRT(NR), .NUMWRPRT(NW), .WIDTH(W), .BITADDR(BA)) bus ();

    algo_3r3w_b798_rdchk #(
        .NUMRDPRT(NR), .NUMWRPRT(NW), .WIDTH(W), .BITADDR(BA),
        .NUMADDR(NA), .RD_LAT(RL), .FLOPOUT(1)
    ) dut (
        .clk(clk), .rst(rst), .flopout_en(flopout_en), .bus(bus),
        .err_vld(err_vld), .err_first(err_first), .err_port(err_port),
        .err_type(err_type), .err_adr(err_adr), .err_exp(err_exp), .err_cnt(err_cnt)
    );

    typedef struct {
        int         due;
        int         port;
        int         typ;
        int         adr;
        logic [W-1:0] exp;
        logic [W-1:0] msk;
    } err_t;

    err_t         sb[$];
    logic [W-1:0] tb_mem  [NA];
    logic [W-1:0] tb_init [NA];
    logic [NR-1:0] sl_vld [8];
    logic [NR-1:0] sl_pipe[8];
    logic [W-1:0] sl_dat [8][NR];
    int           cyc = 0, m_cnt = 0, checks = 0, failures = 0;
    bit           m_first = 0;

    bit           s_rd[NR], s_wr[NW], f_drop[NR], f_spur[NR], f_early[NR];
    int           s_ra[NR], s_wa[NW];
    logic [W-1:0] s_din[NW], s_bw[NW], f_flip[NR];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clr_stim();
        for (int p = 0; p < NR; p++) begin
            s_rd[p] = 0; s_ra[p] = 0; f_drop[p] = 0; f_spur[p] = 0; f_early[p] = 0; f_flip[p] = '0;
        end
        for (int p = 0; p < NW; p++) begin
            s_wr[p] = 0; s_wa[p] = 0; s_din[p] = '0; s_bw[p] = '0;
        end
    endtask

    task automatic push_err(input int due, input int port, input int typ, input int adr,
                            input logic [W-1:0] exp, input logic [W-1:0] msk);
        err_t e;
        e.due = due; e.port = port; e.typ = typ; e.adr = adr; e.exp = exp; e.msk = msk;
        sb.push_back(e);
    endtask

    // One core cycle: drive responses, issue reads/writes, then score the compare.
    task automatic step();
        int s, d, L, a, nerr;
        err_t fe;
        logic [NR-1:0]    rq, rv;
        logic [NR*BA-1:0] ra;
        logic [NR*W-1:0]  rdd;
        logic [NW-1:0]    wq;
        logic [NW*BA-1:0] wa;
        logic [NW*W-1:0]  wd, wb;
        logic [W-1:0]     ex, mk;
        L = RL + (flopout_en ? 1 : 0);
        s = cyc % 8;
        rq = '0; rv = '0; ra = '0; rdd = '0; wq = '0; wa = '0; wd = '0; wb = '0;
        for (int p = 0; p < NR; p++) begin
            rv[p] = sl_vld[s][p];
            rdd[p*W +: W] = sl_dat[s][p];
            if (f_spur[p]) begin
                rv[p] = 1'b1;
                push_err(cyc, p, 2, -1, '0, '0);
            end
        end
        sl_vld[s] = '0;
        sl_pipe[s] = '0;
        for (int p = 0; p < NR; p++) begin
            if (s_rd[p]) begin
                a = s_ra[p];
                ex = tb_mem[a];
                mk = tb_init[a];
                rq[p] = 1'b1;
                ra[p*BA +: BA] = BA'(a);
                d = cyc + L - (f_early[p] ? 1 : 0);
                sl_vld[d % 8][p] = !f_drop[p];
                sl_dat[d % 8][p] = ex ^ f_flip[p];
                sl_pipe[(cyc + L) % 8][p] = 1'b1;
                if (f_drop[p]) push_err(cyc + L, p, 1, a, ex, mk);
                else if (f_early[p]) begin
                    push_err(cyc + L - 1, p, 2, -1, '0, '0);
                    push_err(cyc + L, p, 1, a, ex, mk);
                end else if ((f_flip[p] & mk) != '0) push_err(cyc + L, p, 3, a, ex, mk);
            end
        end
        for (int p = 0; p < NW; p++) begin
            if (s_wr[p]) begin
                a = s_wa[p];
                tb_mem[a]  = (tb_mem[a] & ~s_bw[p]) | (s_din[p] & s_bw[p]);
                tb_init[a] = tb_init[a] | s_bw[p];
                wq[p] = 1'b1;
                wa[p*BA +: BA] = BA'(a);
                wd[p*W +: W] = s_din[p];
                wb[p*W +: W] = s_bw[p];
            end
        end
        bus.read = rq; bus.rd_adr = ra; bus.rd_vld = rv; bus.rd_dout = rdd;
        bus.write = wq; bus.wr_adr = wa; bus.din = wd; bus.bw = wb;
        @(posedge clk);
        #1;
        nerr = 0;
        fe = '{default: 0};
        fe.port = NR;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                nerr++;
                if (sb[i].port < fe.port) fe = sb[i];
                sb.delete(i);
            end
        end
        m_cnt = (m_cnt + nerr > 65535) ? 65535 : m_cnt + nerr;
        chk("err_vld", 32'(err_vld), 32'(nerr > 0));
        chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
        if (nerr > 0 && !m_first) begin
            m_first = 1;
            chk("first_port", 32'(err_port), 32'(fe.port));
            chk("first_type", 32'(err_type), 32'(fe.typ));
            if (fe.typ != 2) begin
                chk("first_adr", 32'(err_adr), 32'(fe.adr));
                chk("first_exp", 32'(err_exp & fe.msk), 32'(fe.exp & fe.msk));
            end
        end
        chk("err_first", 32'(err_first), 32'(m_first));
        cyc++;
        clr_stim();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        clr_stim();
        bus.read = '0; bus.rd_adr = '0; bus.rd_vld = '0; bus.rd_dout = '0;
        bus.write = '0; bus.wr_adr = '0; bus.din = '0; bus.bw = '0;
        sb.delete();
        for (int i = 0; i < 8; i++) begin
            sl_vld[i] = '0; sl_pipe[i] = '0;
            for (int p = 0; p < NR; p++) sl_dat[i][p] = '0;
        end
        for (int a = 0; a < NA; a++) tb_init[a] = '0;
        m_cnt = 0;
        m_first = 0;
        repeat (n) @(posedge clk);
        #1;
        cyc += n;
        chk("rst_err_vld", 32'(err_vld), 0);
        chk("rst_err_first", 32'(err_first), 0);
        chk("rst_err_cnt", 32'(err_cnt), 0);
        chk("rst_err_port", 32'(err_port), 0);
        chk("rst_err_type", 32'(err_type), 0);
        chk("rst_err_adr", 32'(err_adr), 0);
        chk("rst_err_exp", 32'(err_exp), 0);
        rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < NA; a++) tb_mem[a] = '0;
        do_reset(3);

        // write then read back through the latency pipe
        s_wr[0] = 1; s_wa[0] = 5; s_din[0] = 15'h1234; s_bw[0] = 15'h7FFF;
        step();
        s_rd[1] = 1; s_ra[1] = 5;
        step();
        idle(3);
        chk("t1_cnt", 32'(err_cnt), 0);

        // three same-cycle writes to one address: port 2 wins; core returns port 0's data
        for (int p = 0; p < NW; p++) begin
            s_wr[p] = 1; s_wa[p] = 9; s_din[p] = 15'(1 << p); s_bw[p] = 15'h7FFF;
        end
        step();
        s_rd[0] = 1; s_ra[0] = 9; f_flip[0] = 15'h0005;
        s_rd[1] = 1; s_ra[1] = 9;
        step();
        idle(3);
        chk("t2_port", 32'(err_port), 0);
        chk("t2_type", 32'(err_type), 3);
        chk("t2_exp", 32'(err_exp), 32'h4);
        chk("t2_adr", 32'(err_adr), 9);

        // read-old-data on a same-cycle read/write collision
        s_wr[0] = 1; s_wa[0] = 7; s_din[0] = 15'h0; s_bw[0] = 15'h7FFF;
        step();
        s_rd[0] = 1; s_ra[0] = 7;
        s_rd[1] = 1; s_ra[1] = 7; f_flip[1] = 15'h7FFF;
        s_wr[0] = 1; s_wa[0] = 7; s_din[0] = 15'h7FFF; s_bw[0] = 15'h7FFF;
        step();
        idle(3);
        chk("t3_cnt", 32'(err_cnt), 2);

        // missing valid on port 2 plus spurious valid on port 0
        s_rd[2] = 1; s_ra[2] = 5; f_drop[2] = 1; f_spur[0] = 1;
        step();
        idle(3);
        chk("t4_cnt", 32'(err_cnt), 4);
        chk("t4_hold_type", 32'(err_type), 3);

        // random traffic with occasional faults on a small address window
        for (int i = 0; i < 300; i++) begin
            for (int p = 0; p < NR; p++) begin
                s_rd[p] = 1'($urandom_range(0, 1));
                s_ra[p] = $urandom_range(0, 15);
                if ($urandom_range(0, 7) == 0) f_flip[p] = 15'(1 << $urandom_range(0, W - 1));
                if (s_rd[p] && $urandom_range(0, 15) == 0) f_drop[p] = 1;
                if (!sl_vld[cyc % 8][p] && !sl_pipe[cyc % 8][p] && $urandom_range(0, 19) == 0)
                    f_spur[p] = 1;
            end
            for (int p = 0; p < NW; p++) begin
                s_wr[p] = 1'($urandom_range(0, 1));
                s_wa[p] = $urandom_range(0, 15);
                s_din[p] = 15'($urandom);
                s_bw[p] = ($urandom_range(0, 1) == 1) ? 15'h7FFF : 15'($urandom);
            end
            step();
        end
        idle(4);

        // extra output-flop latency
        do_reset(2);
        flopout_en = 1'b1;
        s_wr[0] = 1; s_wa[0] = 5; s_din[0] = 15'h0ABC; s_bw[0] = 15'h7FFF;
        step();
        s_rd[0] = 1; s_ra[0] = 5;
        step();
        idle(4);
        chk("t5_ok_cnt", 32'(err_cnt), 0);
        s_rd[1] = 1; s_ra[1] = 5; f_early[1] = 1;
        step();
        idle(4);
        chk("t5_cnt", 32'(err_cnt), 2);
        chk("t5_port", 32'(err_port), 1);
        chk("t5_type", 32'(err_type), 2);
        flopout_en = 1'b0;
        idle(2);

        // reset while a read is in flight: nothing reported for it
        do_reset(2);
        s_wr[0] = 1; s_wa[0] = 3; s_din[0] = 15'h0055; s_bw[0] = 15'h7FFF;
        step();
        s_rd[0] = 1; s_ra[0] = 3;
        step();
        do_reset(1);
        idle(4);
        chk("midrst_cnt", 32'(err_cnt), 0);

        // counter saturation
        do_reset(2);
        for (int i = 0; i < 21844; i++) begin
            for (int p = 0; p < NR; p++) f_spur[p] = 1;
            step();
        end
        f_spur[0] = 1;
        step();
        chk("sat_fffd", 32'(err_cnt), 32'hFFFD);
        for (int p = 0; p < NR; p++) f_spur[p] = 1;
        step();
        chk("sat_ffff", 32'(err_cnt), 32'hFFFF);
        for (int p = 0; p < NR; p++) f_spur[p] = 1;
        step();
        chk("sat_hold", 32'(err_cnt), 32'hFFFF);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
